// File: rtl/eep_pkg.sv
// eep_pkg: shared state encoding and constants for the EEPROM store controller.
package eep_pkg;
    typedef enum logic [1:0] {IDLE, CPU_ACK, HOST} state_t;
    localparam logic [7:0] EEP_ERASE_VAL = 8'hFF;
    localparam logic [23:0] SAVE_DELAY_DEF = 24'd1000000;
endpackage

// File: rtl/eep_store_ctrl_if.sv
// eep_store_ctrl_if: CPU register-block and host save/load session signals.
interface eep_store_ctrl_if #(parameter int ADDR_W = 16);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              host_sess;
    logic              host_dir;
    logic              host_grant;
    logic              host_wr;
    logic              host_rd;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_rvalid;
    logic [7:0]        host_rdata;
    logic              save_req;
    logic              dirty;
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_sess, host_dir, host_wr, host_rd, host_addr, host_wdata,
        input  cpu_ack, cpu_rdata, host_grant, host_rvalid, host_rdata, save_req, dirty
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_sess, host_dir, host_wr, host_rd, host_addr, host_wdata,
        output cpu_ack, cpu_rdata, host_grant, host_rvalid, host_rdata, save_req, dirty
    );
endinterface

// File: rtl/eep_byte_ram.sv
// eep_byte_ram: single-port byte RAM with registered read, read-before-write.
module eep_byte_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/eep_store_ctrl.sv
// eep_store_ctrl: arbitrates the EEPROM array between CPU byte accesses and host
// save/load sessions, tracks unsaved changes and requests an autosave when quiet.
module eep_store_ctrl
    import eep_pkg::*;
#(
    parameter int          EEP_SIZE   = 512,
    parameter int          ADDR_W     = 16,
    parameter logic [23:0] SAVE_DELAY = SAVE_DELAY_DEF
) (
    input logic clk,
    input logic rst,
    eep_store_ctrl_if.slave bus
);
    localparam int AW = $clog2(EEP_SIZE);
    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(EEP_SIZE);

    state_t      r_state, w_state_nxt;
    logic        r_dir, w_dir_nxt;
    logic        r_ack, w_ack_nxt;
    logic        r_grant, w_grant_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic        r_oor, w_oor_nxt;
    logic        r_dirty, w_dirty_nxt;
    logic        r_save, w_save_nxt;
    logic [23:0] r_cnt, w_cnt_nxt;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_wdata, w_q, w_rdata;
    logic          w_cpu_in, w_host_in;

    assign w_cpu_in  = bus.cpu_addr < SIZE_A;
    assign w_host_in = bus.host_addr < SIZE_A;

    eep_byte_ram #(.DEPTH(EEP_SIZE), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_dir    <= 1'b0;
            r_ack    <= 1'b0;
            r_grant  <= 1'b0;
            r_rvalid <= 1'b0;
            r_oor    <= 1'b0;
            r_dirty  <= 1'b0;
            r_save   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_ack    <= w_ack_nxt;
            r_grant  <= w_grant_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_oor    <= w_oor_nxt;
            r_dirty  <= w_dirty_nxt;
            r_save   <= w_save_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_ack_nxt    = 1'b0;
        w_grant_nxt  = r_grant;
        w_rvalid_nxt = 1'b0;
        w_oor_nxt    = r_oor;
        w_dirty_nxt  = r_dirty;
        w_cnt_nxt    = (r_dirty && r_state != HOST && r_cnt != SAVE_DELAY) ? r_cnt + 24'd1 : r_cnt;
        w_we         = 1'b0;
        w_addr       = bus.cpu_addr[AW-1:0];
        w_wdata      = bus.cpu_wdata;
        case (r_state)
            IDLE: begin
                // host wins a same-cycle tie with the CPU
                if (bus.host_sess) begin
                    w_state_nxt = HOST;
                    w_dir_nxt   = bus.host_dir;
                    w_grant_nxt = 1'b1;
                end else if (bus.cpu_req) begin
                    w_state_nxt = CPU_ACK;
                    w_ack_nxt   = 1'b1;
                    w_oor_nxt   = !w_cpu_in;
                    if (bus.cpu_we && w_cpu_in) begin
                        w_we        = 1'b1;
                        w_dirty_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            CPU_ACK: w_state_nxt = IDLE;
            HOST: begin
                w_addr  = bus.host_addr[AW-1:0];
                w_wdata = bus.host_wdata;
                w_we    = bus.host_wr && r_dir && w_host_in;
                if (bus.host_rd && !r_dir) begin
                    w_rvalid_nxt = 1'b1;
                    w_oor_nxt    = !w_host_in;
                end
                if (!bus.host_sess) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 1'b0;
                    w_dirty_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_save_nxt = w_dirty_nxt && w_cnt_nxt == SAVE_DELAY;
    end

    // read data is gated so both data outputs sit at zero outside their valid cycle
    assign w_rdata         = r_oor ? EEP_ERASE_VAL : w_q;
    assign bus.cpu_ack     = r_ack;
    assign bus.cpu_rdata   = r_ack ? w_rdata : 8'h00;
    assign bus.host_grant  = r_grant;
    assign bus.host_rvalid = r_rvalid;
    assign bus.host_rdata  = r_rvalid ? w_rdata : 8'h00;
    assign bus.save_req    = r_save;
    assign bus.dirty       = r_dirty;
endmodule

// File: tb/tb_eep_store_ctrl.sv
// tb_eep_store_ctrl: directed and randomized checks of eep_store_ctrl against an
// array-level model of the EEPROM contents, dirty flag and autosave timing.
module tb_eep_store_ctrl;
    localparam int DLY = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mem_m [512];
    bit   dirty_m = 1'b0;
    int   q = 0;

    eep_store_ctrl_if #(.ADDR_W(16)) bus ();

    eep_store_ctrl #(.EEP_SIZE(512), .ADDR_W(16), .SAVE_DELAY(24'(DLY))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_save();
        check("save_req", bus.save_req, dirty_m && q >= DLY);
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        cyc();
        check("cpu_ack", bus.cpu_ack, 1);
        if (!we) check("cpu_rdata", bus.cpu_rdata, a < 16'h200 ? mem_m[a[8:0]] : 8'hFF);
        bus.cpu_req = 1'b0;
        if (we && a < 16'h200) begin
            mem_m[a[8:0]] = d; dirty_m = 1'b1; q = 0;
        end else q++;
        check("dirty", bus.dirty, dirty_m);
        cyc();
        q++;
        check("cpu_ack_drop", bus.cpu_ack, 0);
        check_save();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            q++;
            check_save();
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        bus.host_wr = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        cyc();
        bus.host_wr = 1'b0;
        if (a < 16'h200) mem_m[a[8:0]] = d;
        check("host_grant", bus.host_grant, 1);
        check("cpu_stall", bus.cpu_ack, 0);
    endtask

    task automatic host_read(input logic [15:0] a);
        bus.host_rd = 1'b1; bus.host_addr = a;
        cyc();
        bus.host_rd = 1'b0;
        check("host_rvalid", bus.host_rvalid, 1);
        check("host_rdata", bus.host_rdata, a < 16'h200 ? mem_m[a[8:0]] : 8'hFF);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.host_sess = 0; bus.host_dir = 0; bus.host_wr = 0; bus.host_rd = 0;
        bus.host_addr = 0; bus.host_wdata = 0;
        repeat (3) cyc();
        check("rst_ack", bus.cpu_ack, 0);
        check("rst_grant", bus.host_grant, 0);
        check("rst_rvalid", bus.host_rvalid, 0);
        check("rst_save", bus.save_req, 0);
        check("rst_dirty", bus.dirty, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_host_rdata", bus.host_rdata, 0);
        rst = 1'b1;
        cyc();

        cpu_op(1'b1, 16'h010, 8'h5A);
        cpu_op(1'b0, 16'h010, 8'h00);

        // host load and CPU read collide; host wins and fills the whole array
        bus.host_sess = 1'b1; bus.host_dir = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h010;
        cyc();
        check("tie_grant", bus.host_grant, 1);
        check("tie_ack", bus.cpu_ack, 0);
        for (int i = 0; i < 512; i++) host_write(16'(i), 8'($urandom));
        host_write(16'h010, 8'hA5);
        host_write(16'h250, 8'h11);
        bus.host_rd = 1'b1; bus.host_addr = 16'h010;
        cyc();
        bus.host_rd = 1'b0;
        check("wrong_dir_rd", bus.host_rvalid, 0);
        bus.host_sess = 1'b0;
        cyc();
        check("end_grant", bus.host_grant, 0);
        check("end_ack", bus.cpu_ack, 0);
        dirty_m = 1'b0; q = 0;
        cyc();
        check("post_ack", bus.cpu_ack, 1);
        check("post_rdata", bus.cpu_rdata, 8'hA5);
        check("post_dirty", bus.dirty, 0);
        bus.cpu_req = 1'b0;
        cyc();

        // autosave timing, restart by a later write, drop by a write while high
        cpu_op(1'b1, 16'($urandom_range(0, 511)), 8'($urandom));
        idle(9);
        cpu_op(1'b1, 16'($urandom_range(0, 511)), 8'($urandom));
        idle(3);
        cpu_op(1'b1, 16'($urandom_range(0, 511)), 8'($urandom));
        idle(9);
        cpu_op(1'b1, 16'($urandom_range(0, 511)), 8'($urandom));

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) cpu_op(1'b1, 16'($urandom_range(0, 511)), 8'($urandom));
            else cpu_op(1'b0, 16'($urandom_range(0, 639)), 8'h00);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
        end
        idle(10);

        // save session reading the whole image, final read on the last session cycle
        bus.host_sess = 1'b1; bus.host_dir = 1'b0;
        cyc();
        check("save_grant", bus.host_grant, 1);
        bus.host_wr = 1'b1; bus.host_addr = 16'h005; bus.host_wdata = ~mem_m[5];
        cyc();
        bus.host_wr = 1'b0;
        for (int i = 0; i < 511; i++) host_read(16'(i));
        host_read(16'h200);
        bus.host_sess = 1'b0;
        host_read(16'h1FF);
        check("save_end_grant", bus.host_grant, 0);
        check("save_end_dirty", bus.dirty, 0);
        check("save_end_req", bus.save_req, 0);
        dirty_m = 1'b0; q = 0;

        cpu_op(1'b1, 16'h200, 8'h12);
        cpu_op(1'b0, 16'h200, 8'h00);

        // reset in the middle of a load session
        cpu_op(1'b1, 16'h020, 8'h3C);
        idle(10);
        bus.host_sess = 1'b1; bus.host_dir = 1'b1;
        cyc();
        host_write(16'h030, 8'h77);
        rst = 1'b0;
        #1;
        check("arst_grant", bus.host_grant, 0);
        check("arst_save", bus.save_req, 0);
        check("arst_dirty", bus.dirty, 0);
        bus.host_sess = 1'b0;
        dirty_m = 1'b0; q = 0;
        cyc();
        rst = 1'b1;
        cyc();
        cpu_op(1'b0, 16'h020, 8'h00);
        cpu_op(1'b0, 16'h030, 8'h00);
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 511));
            d = 8'($urandom);
            cpu_op(1'b1, a, d);
            cpu_op(1'b0, a, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eep_store_ctrl.md
Name: eep_store_ctrl

Overview:
- Owns the EEPROM byte array. Arbitrates it between the CPU-side EEPROM register block (single-byte read, write and erase requests) and the host save/load session port (MiSTer HPS, bulk stream).
- Tracks unsaved modifications and raises an autosave request to the host once CPU writes have been quiet for a programmable interval.
- Sits between the EEPROM register block and the top-level host interface.

Parameters:
- EEP_SIZE, 512, array depth in bytes.
- ADDR_W, 16, width of the CPU and host address buses.
- SAVE_DELAY, 24'd1000000, number of quiet clk cycles after the last CPU write before save_req is raised (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  8  CPU write data (erase is sent as 8'hFF).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid while cpu_ack is high.
- host_sess  in  1  host session active (level).
- host_dir  in  1  1 = load (host writes the array), 0 = save (host reads the array); sampled when the session starts.
- host_grant  out  1  host owns the array.
- host_wr  in  1  host write strobe; legal only while granted and host_dir = 1.
- host_rd  in  1  host read strobe; legal only while granted and host_dir = 0.
- host_addr  in  ADDR_W  host byte address.
- host_wdata  in  8  host write data.
- host_rvalid  out  1  host read data valid (one cycle after host_rd).
- host_rdata  out  8  host read data.
- save_req  out  1  autosave request to the host.
- dirty  out  1  array differs from the last saved or loaded image.

Behaviour:
- Reset (rst low) clears all state asynchronously: state = IDLE; cpu_ack, cpu_rdata, host_grant, host_rvalid, host_rdata, save_req and dirty all 0; quiet counter 0.
- Array contents are NOT reset. Reset in the middle of a session aborts it; the host must restart the session.
- Array is single-port: one access per cycle, read data registered (1-cycle latency).
- State IDLE:
  - If host_sess = 1: latch host_dir, go to HOST, assert host_grant the next cycle. Host has priority when host_sess and cpu_req arrive in the same cycle.
  - Else if cpu_req = 1: perform the access this cycle and go to CPU_ACK.
    - Write: update the array, set dirty, clear the quiet counter.
    - Read: issue the array read.
- State CPU_ACK:
  - cpu_ack = 1 for exactly one cycle; cpu_rdata is valid for reads.
  - Return to IDLE. A cpu_req still high in the IDLE cycle is treated as a new request; the requester must drop it after the ack.
  - Minimum CPU access period is 2 cycles.
- State HOST:
  - host_grant = 1. CPU requests stall, with cpu_ack held at 0.
  - host_wr writes the array.
  - host_rd gives host_rvalid and host_rdata on the next cycle.
  - When host_sess falls: drop host_grant, clear dirty, save_req and the quiet counter, return to IDLE. This applies to both load and save sessions.
  - A host_rd issued on the last session cycle still returns host_rvalid.
- Out-of-range address (addr >= EEP_SIZE), CPU or host:
  - Writes are dropped and do not set dirty.
  - Reads return 8'hFF.
  - A CPU access is still acked normally.
- Quiet counter and autosave:
  - Counter increments each cycle while dirty = 1 and state != HOST, and saturates at SAVE_DELAY.
  - save_req = 1 when dirty = 1 and the counter equals SAVE_DELAY.
  - save_req stays high until a session ends.
  - A CPU write while save_req is high clears the counter and therefore drops save_req.
- A wrong-direction host strobe (host_wr during a save, host_rd during a load) is ignored.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package eep_pkg:
  - state encoding: IDLE, CPU_ACK, HOST.
  - EEP_ERASE_VAL = 8'hFF.
  - the default SAVE_DELAY value.
- One sub-module, eep_byte_ram: single-port synchronous RAM (EEP_SIZE x 8, registered read, write-enable). It infers block RAM on all platforms.

Test Plan:
- Reset with rst low, then CPU write 0x5A to address 0x010, then CPU read of 0x010 -> cpu_ack one cycle after each request; cpu_rdata = 0x5A; dirty = 1.
- Same cycle: host_sess = 1 (load) and cpu_req = 1 -> host_grant rises and cpu_ack stays 0 for the whole session. Host writes 0xA5 to address 0x010, then host_sess falls -> CPU request is acked 2 cycles later; CPU read of 0x010 returns 0xA5; dirty = 0.
- SAVE_DELAY = 8: one CPU write, then idle -> save_req rises 8 cycles after the write. A CPU write at cycle 5 restarts the count.
- Save session: host reads address 0x000..0x1FF -> host_rvalid one cycle after each host_rd with the correct data. At session end, save_req = 0 and dirty = 0.
- CPU write to address 0x200 with EEP_SIZE = 512 -> acked, dirty stays 0. Read of 0x200 returns 0xFF.
- rst low during a HOST session -> host_grant, save_req and dirty go to 0 immediately. After reset, array data written before reset reads back unchanged.
